// File: rtl/burst_loop_tx_pkg.sv
// Shared definitions for the burst loopback initiator, the burst buffer
// and their benches.
package burst_loop_tx_pkg;

    localparam int BURST_DW      = 8;
    localparam int BURST_NBEAT   = 4;
    localparam int BURST_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } burst_state_e;

endpackage

// File: rtl/burst_loop_tx_piso.sv
// NBEAT x DW parallel-load, shift-out register. The shift is a rotation,
// so after NBEAT shifts the register holds the loaded word again and
// doubles as the shadow copy used for the replay comparison.
module burst_piso #(
    parameter int DW    = 8,
    parameter int NBEAT = 4,
    localparam int W    = DW * NBEAT,
    localparam int BW   = $clog2(NBEAT) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  word_in,
    output logic [DW-1:0] beat,
    output logic [W-1:0]  word,
    output logic [BW-1:0] beat_idx
);

    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

    logic [W-1:0]  sh;
    logic [BW-1:0] idx;

    // Load the word, then rotate one beat per shift; index saturates at the last beat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh  <= '0;
            idx <= '0;
        end else if (load) begin
            sh  <= word_in;
            idx <= '0;
        end else if (shift) begin
            sh  <= {sh[DW-1:0], sh[W-1:DW]};
            idx <= (idx == LAST_BEAT) ? idx : idx + 1'b1;
        end
    end

    assign beat     = sh[DW-1:0];
    assign word     = sh;
    assign beat_idx = idx;

endmodule

// File: rtl/burst_loop_tx.sv
// Loopback initiator: sends an NBEAT-beat burst, waits for the reversed
// replay, reassembles it and reports match / mismatch / timeout.
module burst_loop_tx
    import burst_loop_tx_pkg::*;
#(
    parameter int DW      = BURST_DW,
    parameter int NBEAT   = BURST_NBEAT,
    parameter int TIMEOUT = BURST_TIMEOUT,
    localparam int W      = DW * NBEAT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [W-1:0]  word_in,
    output logic          ready,
    output logic [DW-1:0] tx_data,
    output logic          tx_en,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_en,
    output logic [W-1:0]  rx_word,
    output logic          done,
    output logic          match,
    output logic          timeout,
    output logic [2:0]    fsm_state
);

    localparam int BW = $clog2(NBEAT) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] SEND = ST_SEND;
    localparam logic [2:0] WAIT = ST_WAIT;
    localparam logic [2:0] RECV = ST_RECV;
    localparam logic [2:0] DONE = ST_DONE;

    localparam logic [BW-1:0] LAST_BEAT  = BW'(NBEAT - 1);
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT);

    // Handshake: start is accepted only in a cycle with ready=1; tx_en frames
    // exactly NBEAT consecutive beats; rx_en frames the replay, one beat per
    // cycle while high; done pulses for one cycle with match/timeout valid.

    logic [2:0]    state;
    logic [BW-1:0] rx_cnt;
    logic [TW-1:0] wait_cnt;
    logic          timeout_q;
    logic          short_q;
    logic [BW-1:0] slot;

    logic          piso_load;
    logic          piso_shift;
    logic [DW-1:0] piso_beat;
    logic [W-1:0]  piso_word;
    logic [BW-1:0] piso_idx;

    assign piso_load  = (state == IDLE) && start;
    assign piso_shift = (state == SEND);

    burst_piso #(
        .DW    (DW),
        .NBEAT (NBEAT)
    ) u_piso (
        .CLK      (CLK),
        .RST      (RST),
        .load     (piso_load),
        .shift    (piso_shift),
        .word_in  (word_in),
        .beat     (piso_beat),
        .word     (piso_word),
        .beat_idx (piso_idx)
    );

    // Replay beat k lands in slot NBEAT-1-k so a correct echo rebuilds the word.
    assign slot = LAST_BEAT - rx_cnt;

    // Transaction FSM with replay capture, wait counter and result flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            rx_word   <= '0;
            rx_cnt    <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SEND;
                        rx_word   <= '0;
                        rx_cnt    <= '0;
                        wait_cnt  <= '0;
                        timeout_q <= 1'b0;
                        short_q   <= 1'b0;
                    end
                end
                SEND: begin
                    if (piso_idx == LAST_BEAT) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (rx_en) begin
                        rx_word[(NBEAT-1)*DW +: DW] <= rx_data;
                        rx_cnt <= BW'(1);
                        state  <= RECV;
                    end else if (wait_cnt + 1'b1 == WAIT_LIMIT) begin
                        timeout_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RECV: begin
                    if (rx_en) begin
                        rx_word[int'(slot)*DW +: DW] <= rx_data;
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end else begin
                        short_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign tx_en     = (state == SEND);
    assign tx_data   = tx_en ? piso_beat : '0;
    assign done      = (state == DONE);
    assign timeout   = timeout_q;
    assign match     = done && !short_q && !timeout_q && (rx_word == piso_word);
    assign fsm_state = state;

endmodule

// File: tb/tb_burst_loop_tx.sv
// Directed bench for burst_loop_tx with a per-transaction behavioural model.
module tb_burst_loop_tx;
    import burst_loop_tx_pkg::*;

    localparam int DW      = BURST_DW;
    localparam int NBEAT   = BURST_NBEAT;
    localparam int TIMEOUT = BURST_TIMEOUT;
    localparam int W       = DW * NBEAT;

    logic          CLK;
    logic          RST;
    logic          start;
    logic [W-1:0]  word_in;
    logic          ready;
    logic [DW-1:0] tx_data;
    logic          tx_en;
    logic [DW-1:0] rx_data;
    logic          rx_en;
    logic [W-1:0]  rx_word;
    logic          done;
    logic          match;
    logic          timeout;
    logic [2:0]    fsm_state;

    burst_loop_tx #(
        .DW      (DW),
        .NBEAT   (NBEAT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .word_in   (word_in),
        .ready     (ready),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .rx_data   (rx_data),
        .rx_en     (rx_en),
        .rx_word   (rx_word),
        .done      (done),
        .match     (match),
        .timeout   (timeout),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          ready;
        logic          tx_en;
        logic [DW-1:0] tx_data;
        logic          done;
        logic          match;
        logic          timeout;
        logic [W-1:0]  rx_word;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int t_start  = 0;
    int last_done_cyc = 0;
    logic [W-1:0] last_rx_word = '0;
    logic         last_match   = 1'b0;
    logic         last_timeout = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: one expected entry per driven cycle.
    always @(negedge CLK) begin
        if (done === 1'b1) done_cnt++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ready",   64'(ready),   64'(e.ready));
            check("tx_en",   64'(tx_en),   64'(e.tx_en));
            check("tx_data", 64'(tx_data), 64'(e.tx_data));
            check("done",    64'(done),    64'(e.done));
            if (e.done) begin
                check("match",   64'(match),   64'(e.match));
                check("timeout", 64'(timeout), 64'(e.timeout));
                check("rx_word", 64'(rx_word), 64'(e.rx_word));
                last_rx_word  = rx_word;
                last_match    = match;
                last_timeout  = timeout;
                last_done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Idle cycles; rx_en may be toggled to show it is ignored in IDLE.
    task automatic idle(input int k, input bit poke_rx);
        exp_t x;
        for (int n = 0; n < k; n++) begin
            @(posedge CLK); #1;
            start   = 1'b0;
            rx_en   = poke_rx ? n[0] : 1'b0;
            rx_data = poke_rx ? 8'hEE : 8'h00;
            x.ready = 1'b1; x.tx_en = 1'b0; x.tx_data = '0;
            x.done = 1'b0; x.match = 1'b0; x.timeout = 1'b0; x.rx_word = '0;
            exp_q.push_back(x);
        end
    endtask

    // One transaction starting in an IDLE cycle (n=0). The echo of len beats
    // starts at offset s. Expected outputs follow from the protocol: beats at
    // offsets 1..NBEAT, WAIT from NBEAT+1, done one cycle after the last
    // captured beat, after the first gap, or TIMEOUT cycles into WAIT.
    task automatic run_txn(input logic [W-1:0] w, input int s, input int len,
                           input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                           input logic [DW-1:0] e4, input bit hold);
        logic [DW-1:0] echo [5];
        logic [W-1:0]  mw;
        int            d;
        int            cap;
        exp_t          x;
        echo = '{e0, e1, e2, e3, e4};
        cap  = (len > NBEAT) ? NBEAT : len;
        if (len == 0)          d = NBEAT + 1 + TIMEOUT;
        else if (len >= NBEAT) d = s + NBEAT;
        else                   d = s + len + 1;
        mw = '0;
        for (int k = 0; k < cap; k++) mw[(NBEAT-1-k)*DW +: DW] = echo[k];
        for (int n = 0; n <= d; n++) begin
            @(posedge CLK); #1;
            if (n == 0) t_start = cyc;
            start   = (n == 0) || hold;
            word_in = (n == 0) ? w : ~w;
            rx_en   = (len > 0) && (n >= s) && (n < s + len);
            rx_data = 8'h00;
            if (rx_en) rx_data = echo[n-s];
            x.ready   = (n == 0);
            x.tx_en   = (n >= 1) && (n <= NBEAT);
            x.tx_data = '0;
            if (x.tx_en) x.tx_data = w[(n-1)*DW +: DW];
            x.done    = (n == d);
            x.match   = (cap == NBEAT) && (mw == w);
            x.timeout = (len == 0);
            x.rx_word = mw;
            exp_q.push_back(x);
        end
    endtask

    // Correct reversed echo of w starting at offset s.
    task automatic echo_txn(input logic [W-1:0] w, input int s, input bit hold);
        run_txn(w, s, NBEAT, w[31:24], w[23:16], w[15:8], w[7:0], 8'h00, hold);
    endtask

    // ---------------- directed sequence ----------------
    int done_before;

    initial begin
        RST = 1'b0; start = 1'b0; word_in = '0; rx_data = '0; rx_en = 1'b0;
        #2 RST = 1'b1;
        #2;
        check("rst_ready",   64'(ready),     64'd1);
        check("rst_tx_en",   64'(tx_en),     64'd0);
        check("rst_tx_data", 64'(tx_data),   64'd0);
        check("rst_rx_word", 64'(rx_word),   64'd0);
        check("rst_done",    64'(done),      64'd0);
        check("rst_match",   64'(match),     64'd0);
        check("rst_timeout", 64'(timeout),   64'd0);
        check("rst_state",   64'(fsm_state), 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;

        idle(3, 1'b1);

        // Good echo one cycle after tx_en falls.
        run_txn(32'h44332211, 6, 4, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 1'b0);
        idle(1, 1'b0);
        check("good_word",    64'(last_rx_word), 64'h44332211);
        check("good_match",   64'(last_match),   64'd1);
        check("good_latency", 64'(last_done_cyc - t_start), 64'd10);

        // Corrupted echo.
        run_txn(32'h44332211, 6, 4, 8'h44, 8'h33, 8'hAA, 8'h11, 8'h00, 1'b0);
        idle(1, 1'b0);
        check("bad_word",  64'(last_rx_word), 64'h4433AA11);
        check("bad_match", 64'(last_match),   64'd0);

        // No echo at all.
        run_txn(32'h44332211, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(1, 1'b0);
        check("to_latency", 64'(last_done_cyc - t_start), 64'd21);
        check("to_flag",    64'(last_timeout), 64'd1);
        check("to_word",    64'(last_rx_word), 64'd0);

        // Short echo.
        run_txn(32'h44332211, 6, 3, 8'h44, 8'h33, 8'h22, 8'h00, 8'h00, 1'b0);
        idle(1, 1'b0);
        check("short_word",  64'(last_rx_word), 64'h44332200);
        check("short_match", 64'(last_match),   64'd0);

        // Five-beat echo: the extra beat must be ignored.
        run_txn(32'h44332211, 6, 5, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55, 1'b0);
        idle(2, 1'b0);
        check("long_match", 64'(last_match), 64'd1);

        // Echo in the very first WAIT cycle and in the last one before timeout.
        echo_txn(32'hDEADBEEF, 5, 1'b0);
        idle(1, 1'b0);
        echo_txn(32'h01020304, NBEAT + TIMEOUT, 1'b0);
        idle(1, 1'b0);
        check("late_match", 64'(last_match), 64'd1);

        // start held with another word during the transaction, then back-to-back.
        echo_txn(32'hA1B2C3D4, 7, 1'b1);
        echo_txn(32'h0F1E2D3C, 6, 1'b0);
        idle(1, 1'b0);
        check("b2b_word", 64'(last_rx_word), 64'h0F1E2D3C);

        // Reset during SEND beat 2 aborts without done.
        @(posedge CLK); #1;
        start = 1'b1; word_in = 32'h44332211;
        @(posedge CLK); #1; start = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("mid_tx_data", 64'(tx_data), 64'h33);
        done_before = done_cnt;
        RST = 1'b1;
        #1;
        check("abort_tx_en",   64'(tx_en),   64'd0);
        check("abort_tx_data", 64'(tx_data), 64'd0);
        check("abort_ready",   64'(ready),   64'd1);
        @(negedge CLK) RST = 1'b0;
        idle(3, 1'b0);
        echo_txn(32'h99887766, 6, 1'b0);
        idle(2, 1'b0);
        check("abort_no_done", 64'(done_cnt - done_before), 64'd1);
        check("abort_recover", 64'(last_rx_word), 64'h99887766);

        @(posedge CLK);
        @(posedge CLK);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/burst_loop_tx.md
Name: burst_loop_tx

Overview:
Initiator end of the team's enable-framed byte-burst buffer interface. Loads an NBEAT-beat word and transmits it as a contiguous burst: tx_en high, one beat per cycle. It then waits for the buffer's replay burst, reassembles it, and checks it against the sent word. It reports match, mismatch, or timeout, and is used as the loopback initiator and checker in front of the burst buffer.

Parameters:
DW, 8, beat width in bits
NBEAT, 4, beats per burst (>=2)
TIMEOUT, 16, max idle cycles in WAIT before giving up (>=1)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, asynchronous, active-high
start  in  1  request to send word_in; honoured only when ready=1
word_in  in  DW*NBEAT  payload; beat i = word_in[i*DW +: DW]
ready  out  1  high only in IDLE
tx_data  out  DW  beat to peer; 0 when tx_en=0
tx_en  out  1  burst frame to peer
rx_data  in  DW  replay beat from peer
rx_en  in  1  replay frame from peer
rx_word  out  DW*NBEAT  reassembled replay
done  out  1  one-cycle completion pulse
match  out  1  valid with done: rx_word == sent word
timeout  out  1  valid with done: no replay within TIMEOUT

Behaviour:
- Reset (async, any state): state IDLE, ready=1, tx_en=0, tx_data=0, rx_word=0, done=0, match=0, timeout=0, counters 0. A reset mid-burst aborts the transaction without emitting done.
- All outputs are registered or decoded directly from registered state. No combinational path from input to output.
- States: IDLE, SEND, WAIT, RECV, DONE.
- IDLE: ready=1. When start=1, latch word_in into the shadow register and clear rx_word; next state SEND. rx_en in IDLE is ignored.
- SEND: exactly NBEAT consecutive cycles with tx_en=1. Cycle i drives tx_data = shadow beat i, beat 0 first. If start=1 at cycle t, tx_en is high in cycles t+1..t+NBEAT. start and rx_en are ignored in SEND. After the last beat, go to WAIT; tx_en and tx_data return to 0.
- WAIT: a wait counter increments each cycle while rx_en=0.
  - rx_en=1: capture that beat as replay beat 0 and go to RECV.
  - Counter reaches TIMEOUT with no rx_en: go to DONE with timeout=1, match=0.
- Replay order: the peer returns beats in reverse order. Replay beat k is stored at rx_word slot NBEAT-1-k, so a correct replay gives rx_word == word_in.
- RECV: capture one beat per cycle while rx_en=1. After NBEAT beats total, go to DONE. If rx_en drops early (short burst), go to DONE with match=0; captured slots are kept and the rest stay 0.
- DONE: one cycle. done=1 and match = (no short burst) AND (rx_word == shadow). timeout holds its value. Next state IDLE.
- done, match, and timeout are meaningful only while done=1. match and timeout clear when the next transaction's SEND begins.
- Extra rx_en beats after the NBEAT-th are ignored: DONE and IDLE do not capture.
- Back-to-back transactions: start asserted in the IDLE cycle immediately after DONE is accepted.
- Counter widths are $clog2 of their limit +1. Beat index is compared against NBEAT-1, with no wrap-around past NBEAT.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SEND, WAIT, RECV, DONE);
  - default constants BURST_DW=8, BURST_NBEAT=4, BURST_TIMEOUT=16, reused by the burst buffer and the benches.
- One natural sub-module: burst_piso. It is the NBEAT x DW parallel-load, shift-out register driving tx_data, with load, shift, and beat-index outputs. The FSM, compare, and timeout logic stay in the top module.

Test Plan:
- DW=8, NBEAT=4, word_in=0x44332211, start pulse at cycle t -> tx_en high in cycles t+1..t+4 with tx_data 11,22,33,44. Bench echoes 44,33,22,11 starting 1 cycle after tx_en falls -> one done pulse, match=1, timeout=0, rx_word=0x44332211, ready=1 the next cycle.
- Same stimulus, echo 44,33,AA,11 -> done=1, match=0, rx_word=0x4433AA11.
- No echo -> done=1 exactly TIMEOUT=16 cycles after entering WAIT, timeout=1, match=0, rx_word=0.
- Echo 44,33,22 then rx_en low -> done=1, match=0, rx_word=0x44332200. A 5-beat echo instead gives match=1 and the 5th beat is ignored.
- start held high during SEND/WAIT/RECV with a different word_in -> ignored. A new transaction starts only from IDLE, and two back-to-back transactions both match.
- RST pulsed during SEND beat 2 -> tx_en=0, tx_data=0, ready=1 immediately, no done pulse, and the next start transmits cleanly from beat 0.
